// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined channel multiplexer: mode encodings and width helper.
package mips_pkg;

    localparam int unsigned MUX_MODE_SEL = 0;
    localparam int unsigned MUX_MODE_RR  = 1;

    // Ceiling log2, never below 1 so a select field always has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < n) w = i + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requesting channel at or after ptr, wrapping upward.
module rr_arbiter #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N_IN-1:0]  grant,
    output logic [SEL_W-1:0] grant_idx
);

    // Distance k from ptr is the priority; channel i sits at ptr+k, possibly wrapped once.
    always_comb begin
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned k = 0; k < N_IN; k++) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (!found && req[i] &&
                    ((32'(ptr) + k == i) || (32'(ptr) + k == i + N_IN))) begin
                    found     = 1'b1;
                    grant[i]  = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mux_pipe_n.sv
// N-input registered multiplexer with valid/ready handshake, explicit or round-robin selection.
// Optional one-entry skid buffer enabled by defining MUX_PIPE_N_SKID_EN.
module mux_pipe_n
    import mips_pkg::*;
#(
    parameter int unsigned SIZE  = 32,
    parameter int unsigned N_IN  = 4,
    parameter int unsigned MODE  = MUX_MODE_SEL,
    localparam int unsigned SEL_W = (clog2(N_IN) < 1) ? 1 : clog2(N_IN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_IN*SIZE-1:0] in_data,
    input  logic [N_IN-1:0]      in_valid,
    output logic [N_IN-1:0]      in_ready,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 flush,
    output logic [SIZE-1:0]      out_data,
    output logic [SEL_W-1:0]     out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [N_IN-1:0]  grant;
    logic [SEL_W-1:0] grant_idx;
    logic             accept;
    logic             xfer;
    logic [SIZE-1:0]  new_data;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [SEL_W-1:0] ptr;
            logic             unused_sel;

            assign unused_sel = ^sel;

            rr_arbiter #(
                .N_IN  (N_IN),
                .SEL_W (SEL_W)
            ) u_arb (
                .req       (in_valid),
                .ptr       (ptr),
                .grant     (grant),
                .grant_idx (grant_idx)
            );

            // Pointer advances past the winner only on an actual transfer.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ptr <= '0;
                end else if (xfer) begin
                    ptr <= (32'(grant_idx) == N_IN - 1) ? '0 : grant_idx + SEL_W'(1);
                end
            end
        end else begin : g_sel
            // Out-of-range select leaves every grant bit low.
            always_comb begin
                grant = '0;
                for (int unsigned i = 0; i < N_IN; i++) begin
                    grant[i] = (32'(sel) == i);
                end
            end
            assign grant_idx = sel;
        end
    endgenerate

    assign in_ready = grant & {N_IN{accept}};
    assign xfer     = |(in_ready & in_valid);

    always_comb begin
        new_data = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (32'(grant_idx) == i) new_data = in_data[i*SIZE +: SIZE];
        end
    end

`ifdef MUX_PIPE_N_SKID_EN
    logic             skid_full;
    logic [SIZE-1:0]  skid_data;
    logic [SEL_W-1:0] skid_src;

    // Room depends only on registered state, cutting the out_ready -> in_ready path.
    assign accept = rst_n && !flush && !skid_full;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            skid_full <= 1'b0;
            skid_data <= '0;
            skid_src  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_full) begin
                out_valid <= 1'b1;
                out_data  <= skid_data;
                out_src   <= skid_src;
                skid_full <= 1'b0;
            end else begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= new_data;
                    out_src  <= grant_idx;
                end
            end
        end else if (xfer) begin
            skid_full <= 1'b1;
            skid_data <= new_data;
            skid_src  <= grant_idx;
        end
    end
`else
    assign accept = rst_n && !flush && (!out_valid || out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            out_valid <= xfer;
            if (xfer) begin
                out_data <= new_data;
                out_src  <= grant_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mux_pipe_n.sv
// Bench for mux_pipe_n: three instances (select N=4, round-robin N=4, select N=3) against an occupancy model.
module tb_mux_pipe_n;

`ifdef MUX_PIPE_N_SKID_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = 1;
`endif
    localparam int unsigned NN[3]    = '{4, 4, 3};
    localparam int unsigned MODES[3] = '{0, 1, 0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [1:0]   sel;
    logic         flush;
    logic         out_ready;

    logic [3:0]   rdy0, rdy1;
    logic [2:0]   rdy2;
    logic [31:0]  od0, od1, od2;
    logic [1:0]   os0, os1, os2;
    logic         ov0, ov1, ov2;

    int checks = 0;
    int errors = 0;

    // Model: words held per instance (output plus optional skid), round-robin pointer, last loaded output.
    int unsigned cnt [3];
    int unsigned ptr [3];
    logic [31:0] qd  [3][2];
    int unsigned qs  [3][2];
    logic [31:0] md  [3];
    int unsigned ms  [3];

    always #5 clk = ~clk;

    mux_pipe_n #(.SIZE(32), .N_IN(4), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
        .sel(sel), .flush(flush), .out_data(od0), .out_src(os0), .out_valid(ov0), .out_ready(out_ready));
    mux_pipe_n #(.SIZE(32), .N_IN(4), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
        .sel(sel), .flush(flush), .out_data(od1), .out_src(os1), .out_valid(ov1), .out_ready(out_ready));
    mux_pipe_n #(.SIZE(32), .N_IN(3), .MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data[95:0]), .in_valid(in_valid[2:0]), .in_ready(rdy2),
        .sel(sel), .flush(flush), .out_data(od2), .out_src(os2), .out_valid(ov2), .out_ready(out_ready));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            cnt[k] = 0; ptr[k] = 0; md[k] = '0; ms[k] = 0;
        end
    endtask

    // One clock: check registered outputs, drive inputs, check in_ready, advance model, wait an edge.
    task automatic step(input logic r, input logic [3:0] v, input logic [1:0] s,
                        input logic f, input logic o, input logic [127:0] d);
        logic [3:0]  grdy;
        logic [31:0] god;
        int unsigned gos;
        logic        gov;
        logic        acc, found, xf;
        int unsigned g, n;
        logic [3:0]  exp_rdy;

        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin god = od0; gos = 32'(os0); gov = ov0; end
                1:       begin god = od1; gos = 32'(os1); gov = ov1; end
                default: begin god = od2; gos = 32'(os2); gov = ov2; end
            endcase
            check($sformatf("d%0d.out_valid", k), 64'(gov), 64'(cnt[k] > 0));
            check($sformatf("d%0d.out_data", k), 64'(god), 64'(md[k]));
            check($sformatf("d%0d.out_src", k), 64'(gos), 64'(ms[k]));
        end

        rst_n = r; in_valid = v; sel = s; flush = f; out_ready = o; in_data = d;
        #1;

        for (int k = 0; k < 3; k++) begin
            n   = NN[k];
            acc = r && !f && ((CAP == 2) ? (cnt[k] < 2) : (cnt[k] == 0 || o));
            found = 1'b0; g = 0;
            if (MODES[k] == 0) begin
                if (32'(s) < n) begin found = 1'b1; g = 32'(s); end
            end else begin
                for (int j = 0; j < int'(n); j++) begin
                    int unsigned c;
                    c = (ptr[k] + 32'(j)) % n;
                    if (!found && v[c]) begin found = 1'b1; g = c; end
                end
            end
            exp_rdy = (acc && found) ? (4'b0001 << g) : 4'b0000;
            xf      = acc && found && v[g];
            case (k)
                0:       grdy = rdy0;
                1:       grdy = rdy1;
                default: grdy = {1'b0, rdy2};
            endcase
            check($sformatf("d%0d.in_ready", k), 64'(grdy), 64'(exp_rdy));

            if (!r) begin
                cnt[k] = 0; ptr[k] = 0; md[k] = '0; ms[k] = 0;
            end else if (f) begin
                cnt[k] = 0;
            end else begin
                if (cnt[k] > 0 && o) begin
                    qd[k][0] = qd[k][1]; qs[k][0] = qs[k][1]; cnt[k]--;
                end
                if (xf) begin
                    qd[k][cnt[k]] = d[g*32 +: 32]; qs[k][cnt[k]] = g; cnt[k]++;
                    ptr[k] = (g + 1) % n;
                end
                if (cnt[k] > 0) begin md[k] = qd[k][0]; ms[k] = qs[k][0]; end
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        logic [127:0] d;
        rst_n = 1'b0; in_valid = 4'hF; sel = 2'd0; flush = 1'b0; out_ready = 1'b1; in_data = rnd128();
        #1;
        check("reset.in_ready0", 64'(rdy0), 64'(0));
        check("reset.in_ready1", 64'(rdy1), 64'(0));
        check("reset.in_ready2", 64'(rdy2), 64'(0));
        repeat (2) @(negedge clk);
        model_reset();
        step(1'b0, 4'hF, 2'd1, 1'b0, 1'b1, rnd128());

        // Explicit select of channel 2 with a known word.
        d = rnd128(); d[95:64] = 32'hA5A5_A5A5;
        step(1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, d);
        check("sel2.valid", 64'(ov0), 64'(1));
        check("sel2.data", 64'(od0), 64'h0000_0000_A5A5_A5A5);
        check("sel2.src", 64'(os0), 64'(2));

        // Round-robin wrap: pointer now 3, only channels 0 and 1 request.
        step(1'b1, 4'b0011, 2'd0, 1'b0, 1'b1, rnd128());
        check("rr_wrap.src0", 64'(os1), 64'(0));
        step(1'b1, 4'b0011, 2'd0, 1'b0, 1'b1, rnd128());
        check("rr_wrap.src1", 64'(os1), 64'(1));

        // Round-robin rotation after reset with every channel requesting.
        step(1'b0, 4'hF, 2'd0, 1'b0, 1'b1, rnd128());
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'hF, 2'd0, 1'b0, 1'b1, rnd128());
            check($sformatf("rr_seq%0d", i), 64'(os1), 64'(i % 4));
        end

        // Out-of-range select on the three-channel instance.
        step(1'b1, 4'b0111, 2'd3, 1'b0, 1'b1, rnd128());
        step(1'b1, 4'b0111, 2'd3, 1'b0, 1'b1, rnd128());
        check("sel_oor.valid", 64'(ov2), 64'(0));

        // Three-cycle stall with input pending, then drain.
        step(1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, rnd128());
        repeat (3) step(1'b1, 4'hF, 2'd2, 1'b0, 1'b0, rnd128());
        repeat (3) step(1'b1, 4'h0, 2'd2, 1'b0, 1'b1, rnd128());

        // Flush while holding output with a valid input present.
        step(1'b1, 4'hF, 2'd1, 1'b0, 1'b0, rnd128());
        step(1'b1, 4'hF, 2'd1, 1'b1, 1'b1, rnd128());
        check("flush.valid", 64'(ov0), 64'(0));
        step(1'b1, 4'hF, 2'd1, 1'b0, 1'b1, rnd128());

        // Randomized traffic with occasional flush, stall and reset.
        for (int i = 0; i < 800; i++) begin
            logic [3:0] v;
            v = 4'($urandom());
            if ($urandom_range(0, 3) == 0) v = 4'hF;
            step(($urandom_range(0, 199) != 0), v, 2'($urandom()),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), rnd128());
        end
        step(1'b1, 4'h0, 2'd0, 1'b0, 1'b1, rnd128());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
